// File: rtl/dfr_reservoir_responder.sv
// -----------------------------------------------------------------------------
// dfr_reservoir_responder
//
// Reservoir-side responder for the DFR core. Each accepted sample request
// walks NUM_VIRTUAL_NODES delay-loop nodes, one per cycle:
//   node[k] <= sat(sample + (node[k] >>> 1))
// Results of recorded samples are streamed to the reservoir-history memory.
// A one-cycle valid pulse ends every accepted request.
//
// Ports
//   i_clk                   rising-edge clock
//   i_rst                   asynchronous active-low reset (0 = reset)
//   i_reservoir_rst         synchronous clear request from the controller
//   i_reservoir_en          one-cycle sample request
//   i_reservoir_history_en  marks the request as recorded
//   i_sample_in             signed input sample, captured with the request
//   o_reservoir_valid       one-cycle completion pulse
//   o_reservoir_init_busy   warm-up not yet complete
//   o_reservoir_filled      warm-up complete
//   o_reservoir_busy        recorded samples remain
//   o_history_wr_en         history write strobe
//   o_history_wr_addr       history write address
//   o_history_wr_data       node value written to history
//   o_protocol_err          sticky request-violation flag
// -----------------------------------------------------------------------------
module dfr_reservoir_responder #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int NUM_INIT_SAMPLES  = 3,
  parameter int NUM_SAMPLES       = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_reservoir_rst,
  input  logic                         i_reservoir_en,
  input  logic                         i_reservoir_history_en,
  input  logic signed [DATA_WIDTH-1:0] i_sample_in,
  output logic                         o_reservoir_valid,
  output logic                         o_reservoir_init_busy,
  output logic                         o_reservoir_filled,
  output logic                         o_reservoir_busy,
  output logic                         o_history_wr_en,
  output logic        [ADDR_WIDTH-1:0] o_history_wr_addr,
  output logic signed [DATA_WIDTH-1:0] o_history_wr_data,
  output logic                         o_protocol_err
);

  localparam int TOTAL_SAMPLES = NUM_INIT_SAMPLES + NUM_SAMPLES;
  localparam int CNT_W         = $clog2(TOTAL_SAMPLES + 1);
  localparam int IDX_W         = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;

  localparam logic [CNT_W-1:0]      INIT_CNT  = CNT_W'(NUM_INIT_SAMPLES);
  localparam logic [CNT_W-1:0]      TOTAL_CNT = CNT_W'(TOTAL_SAMPLES);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_VIRTUAL_NODES - 1);
  localparam logic [ADDR_WIDTH-1:0] NODES_A   = ADDR_WIDTH'(NUM_VIRTUAL_NODES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_VALID   = 2'd2
  } state_t;

  // Add at DATA_WIDTH+1 bits and clamp to the signed DATA_WIDTH range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat_add = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat_add = sum[DATA_WIDTH-1:0];
    end
  endfunction

  state_t                      r_state;
  logic [IDX_W-1:0]            r_node_idx;
  logic [CNT_W-1:0]            r_sample_cnt;
  logic signed [DATA_WIDTH-1:0] r_sample_q;
  logic                        r_hist_q;
  logic signed [DATA_WIDTH-1:0] r_delay_line [NUM_VIRTUAL_NODES];

  logic                         w_init_busy;
  logic                         w_step;
  logic [IDX_W-1:0]             w_calc_idx;
  logic signed [DATA_WIDTH-1:0] w_calc_sample;
  logic                         w_calc_hist;
  logic signed [DATA_WIDTH-1:0] w_delay_sel;
  logic signed [DATA_WIDTH-1:0] w_half;
  logic signed [DATA_WIDTH-1:0] w_new;
  logic [CNT_W-1:0]             w_rel_cnt;
  logic [ADDR_WIDTH-1:0]        w_addr;

  assign w_init_busy           = (r_sample_cnt < INIT_CNT);
  assign o_reservoir_init_busy = w_init_busy;
  assign o_reservoir_filled    = (r_sample_cnt >= INIT_CNT);
  assign o_reservoir_busy      = (r_sample_cnt < TOTAL_CNT);

  // The history outputs are registered, so the node shown during a COMPUTE
  // cycle is evaluated on the edge that opens that cycle: node 0 on the accept
  // edge (straight from the request inputs), node k+1 while node k is shown.
  always_comb begin
    w_step        = 1'b0;
    w_calc_idx    = '0;
    w_calc_sample = r_sample_q;
    w_calc_hist   = r_hist_q;
    if (r_state == S_IDLE) begin
      w_calc_sample = i_sample_in;
      w_calc_hist   = i_reservoir_history_en & ~w_init_busy;
    end else if ((r_state == S_COMPUTE) && (r_node_idx != LAST_IDX)) begin
      w_step     = 1'b1;
      w_calc_idx = r_node_idx + IDX_W'(1);
    end else begin
      w_step     = 1'b0;
    end
    w_delay_sel = r_delay_line[w_calc_idx];
    w_half      = w_delay_sel >>> 1;
    w_new       = sat_add(w_calc_sample, w_half);
    // Only meaningful once warm-up is over; writes are suppressed before that.
    w_rel_cnt   = r_sample_cnt - INIT_CNT;
    w_addr      = ADDR_WIDTH'(w_rel_cnt) * NODES_A + ADDR_WIDTH'(w_calc_idx);
  end

  // Request FSM, node evaluation, delay line and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state           <= S_IDLE;
      r_node_idx        <= '0;
      r_sample_cnt      <= '0;
      r_sample_q        <= '0;
      r_hist_q          <= 1'b0;
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) r_delay_line[i] <= '0;
      o_reservoir_valid <= 1'b0;
      o_history_wr_en   <= 1'b0;
      o_history_wr_addr <= '0;
      o_history_wr_data <= '0;
      o_protocol_err    <= 1'b0;
    end else if (i_reservoir_rst) begin
      // Clear request wins over a simultaneous sample request, silently.
      r_state           <= S_IDLE;
      r_node_idx        <= '0;
      r_sample_cnt      <= '0;
      r_sample_q        <= '0;
      r_hist_q          <= 1'b0;
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++) r_delay_line[i] <= '0;
      o_reservoir_valid <= 1'b0;
      o_history_wr_en   <= 1'b0;
      o_history_wr_addr <= '0;
      o_history_wr_data <= '0;
      o_protocol_err    <= 1'b0;
    end else begin
      o_reservoir_valid <= 1'b0;
      o_history_wr_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_reservoir_en) begin
            if (r_sample_cnt < TOTAL_CNT) begin
              r_sample_q               <= i_sample_in;
              r_hist_q                 <= w_calc_hist;
              r_node_idx               <= '0;
              r_state                  <= S_COMPUTE;
              r_delay_line[w_calc_idx] <= w_new;
              o_history_wr_en          <= w_calc_hist;
              if (w_calc_hist) begin
                o_history_wr_addr <= w_addr;
                o_history_wr_data <= w_new;
              end
              // Recording during warm-up is a violation; the sample still runs.
              if (i_reservoir_history_en && w_init_busy) begin
                o_protocol_err <= 1'b1;
              end
            end else begin
              o_protocol_err <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (i_reservoir_en) begin
            o_protocol_err <= 1'b1;
          end
          if (w_step) begin
            r_node_idx               <= w_calc_idx;
            r_delay_line[w_calc_idx] <= w_new;
            o_history_wr_en          <= r_hist_q;
            if (r_hist_q) begin
              o_history_wr_addr <= w_addr;
              o_history_wr_data <= w_new;
            end
          end else begin
            r_state           <= S_VALID;
            o_reservoir_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (i_reservoir_en) begin
            o_protocol_err <= 1'b1;
          end
          r_sample_cnt <= r_sample_cnt + CNT_W'(1);
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_reservoir_responder.sv
module tb_dfr_reservoir_responder;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rrst;
  logic          en;
  logic          hen;
  logic [DW-1:0] sample;
  logic          valid, init_busy, filled, busy, wr_en, perr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  int wcount   = 0;
  logic [31:0] waddr_log [64];
  logic [31:0] wdata_log [64];

  dfr_reservoir_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VIRTUAL_NODES(4),
    .NUM_INIT_SAMPLES(2), .NUM_SAMPLES(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_reservoir_rst(rrst), .i_reservoir_en(en),
    .i_reservoir_history_en(hen), .i_sample_in(sample),
    .o_reservoir_valid(valid), .o_reservoir_init_busy(init_busy),
    .o_reservoir_filled(filled), .o_reservoir_busy(busy),
    .o_history_wr_en(wr_en), .o_history_wr_addr(wr_addr),
    .o_history_wr_data(wr_data), .o_protocol_err(perr)
  );

  always #5 clk = ~clk;

  // Log valid pulses and history writes mid-cycle.
  always @(negedge clk) begin
    if (valid) vcount++;
    if (wr_en && wcount < 64) begin
      waddr_log[wcount] = 32'(wr_addr);
      wdata_log[wcount] = 32'(wr_data);
      wcount++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for valid; lat counts the cycle after the request edge as 1.
  task automatic wait_valid(input int start, input string tag);
    int lat;
    lat = start;
    while (!valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk(tag, 32'(lat), 32'd5);
    cyc();
  endtask

  task automatic req(input logic [DW-1:0] s, input logic h);
    en = 1'b1; hen = h; sample = s;
    cyc();
    en = 1'b0; hen = 1'b0;
    wait_valid(1, "latency");
  endtask

  task automatic soft_clear();
    rrst = 1'b1;
    cyc();
    rrst = 1'b0;
  endtask

  int w0, v0;

  initial begin
    rst = 1'b0; rrst = 1'b0; en = 1'b0; hen = 1'b0; sample = 16'd0;
    repeat (2) cyc();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_err", 32'(perr), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_filled", 32'(filled), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();

    // Warm-up: delay line becomes 100 then 150, nothing written.
    w0 = wcount; v0 = vcount;
    req(16'd100, 1'b0);
    chk("warm1_init_busy", 32'(init_busy), 32'd1);
    chk("warm1_filled", 32'(filled), 32'd0);
    req(16'd100, 1'b0);
    chk("warm2_filled", 32'(filled), 32'd1);
    chk("warm2_init_busy", 32'(init_busy), 32'd0);
    chk("warm_writes", 32'(wcount - w0), 32'd0);
    chk("warm_valids", 32'(vcount - v0), 32'd2);

    // Recorded: 10+75=85, 10+42=52, 10+26=36 on addresses 0..11.
    w0 = wcount;
    req(16'd10, 1'b1);
    req(16'd10, 1'b1);
    chk("rec2_busy", 32'(busy), 32'd1);
    req(16'd10, 1'b1);
    chk("rec3_busy", 32'(busy), 32'd0);
    chk("rec_writes", 32'(wcount - w0), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("rec_addr", waddr_log[w0 + i], 32'(i));
      chk("rec_data", wdata_log[w0 + i], (i < 4) ? 32'd85 : ((i < 8) ? 32'd52 : 32'd36));
    end
    chk("rec_err", 32'(perr), 32'd0);

    // Request beyond the recorded budget.
    v0 = vcount;
    en = 1'b1; cyc(); en = 1'b0;
    repeat (8) cyc();
    chk("over_valids", 32'(vcount - v0), 32'd0);
    chk("over_err", 32'(perr), 32'd1);

    // Positive saturation.
    soft_clear();
    chk("clr_err", 32'(perr), 32'd0);
    req(16'h7fff, 1'b0);
    req(16'h7fff, 1'b0);
    w0 = wcount;
    req(16'h7fff, 1'b1);
    chk("satp_writes", 32'(wcount - w0), 32'd4);
    chk("satp_data0", wdata_log[w0], 32'h7fff);
    chk("satp_data3", wdata_log[w0 + 3], 32'h7fff);

    // Negative saturation.
    soft_clear();
    req(16'h8000, 1'b0);
    req(16'h8000, 1'b0);
    w0 = wcount;
    req(16'h8000, 1'b1);
    chk("satn_data0", wdata_log[w0], 32'h8000);
    chk("satn_data3", wdata_log[w0 + 3], 32'h8000);

    // Request while computing: flagged, only one valid.
    soft_clear();
    v0 = vcount;
    en = 1'b1; sample = 16'd5;
    cyc();
    cyc();
    en = 1'b0;
    wait_valid(2, "busy_req_latency");
    chk("busy_req_err", 32'(perr), 32'd1);
    chk("busy_req_valids", 32'(vcount - v0), 32'd1);

    // Recording during warm-up: flagged, no writes, sample still completes.
    soft_clear();
    w0 = wcount; v0 = vcount;
    req(16'd7, 1'b1);
    chk("warm_hist_err", 32'(perr), 32'd1);
    chk("warm_hist_writes", 32'(wcount - w0), 32'd0);
    chk("warm_hist_valids", 32'(vcount - v0), 32'd1);

    // Clear request in COMPUTE cycle 2 alongside a sample request.
    soft_clear();
    req(16'd1, 1'b0);
    req(16'd1, 1'b0);
    v0 = vcount;
    en = 1'b1; sample = 16'd3;
    cyc();
    cyc();
    chk("mid_err_before", 32'(perr), 32'd1);
    rrst = 1'b1;
    cyc();
    rrst = 1'b0; en = 1'b0;
    chk("mid_err", 32'(perr), 32'd0);
    chk("mid_filled", 32'(filled), 32'd0);
    chk("mid_init_busy", 32'(init_busy), 32'd1);
    chk("mid_wr_en", 32'(wr_en), 32'd0);
    repeat (8) cyc();
    chk("mid_valids", 32'(vcount - v0), 32'd0);
    req(16'd3, 1'b0);

    // Asynchronous reset in the middle of a recorded sample.
    soft_clear();
    req(16'd1, 1'b0);
    req(16'd1, 1'b0);
    en = 1'b1; hen = 1'b1; sample = 16'd9;
    cyc();
    en = 1'b0; hen = 1'b0;
    cyc();
    chk("async_pre_wr_en", 32'(wr_en), 32'd1);
    chk("async_pre_addr", 32'(wr_addr), 32'd1);
    chk("async_pre_data", 32'(wr_data), 32'd9);
    #1 rst = 1'b0;
    #1;
    chk("async_wr_en", 32'(wr_en), 32'd0);
    chk("async_addr", 32'(wr_addr), 32'd0);
    chk("async_data", 32'(wr_data), 32'd0);
    chk("async_filled", 32'(filled), 32'd0);
    chk("async_init_busy", 32'(init_busy), 32'd1);
    v0 = vcount;
    cyc();
    rst = 1'b1;
    repeat (8) cyc();
    chk("async_valids", 32'(vcount - v0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
